// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, mux codes, control word.
// State TRAP is only reachable when MULTICYCLE_TRAP_EN is defined.
package mips_ctrl_pkg;

    localparam int unsigned ST_BITS = 4;

    localparam logic [ST_BITS-1:0] S_FETCH   = 4'd0;
    localparam logic [ST_BITS-1:0] S_DECODE  = 4'd1;
    localparam logic [ST_BITS-1:0] S_MEMADR  = 4'd2;
    localparam logic [ST_BITS-1:0] S_MEMRD   = 4'd3;
    localparam logic [ST_BITS-1:0] S_MEMWB   = 4'd4;
    localparam logic [ST_BITS-1:0] S_MEMWR   = 4'd5;
    localparam logic [ST_BITS-1:0] S_EXECUTE = 4'd6;
    localparam logic [ST_BITS-1:0] S_ALUWB   = 4'd7;
    localparam logic [ST_BITS-1:0] S_BRANCH  = 4'd8;
    localparam logic [ST_BITS-1:0] S_ADDIEX  = 4'd9;
    localparam logic [ST_BITS-1:0] S_ADDIWB  = 4'd10;
    localparam logic [ST_BITS-1:0] S_JUMP    = 4'd11;
    localparam logic [ST_BITS-1:0] S_TRAP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control word, before mem_ready/zero/reset gating
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_outdec.sv
// Pure state -> control word decode; unlisted and unused states give an all-zero word.
module multicycle_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic [STATE_W-1:0] i_state,
    output ctrl_t              o_ctrl_c
);

    always_comb begin
        o_ctrl_c = '0;
        case (i_state)
            STATE_W'(S_FETCH): begin
                o_ctrl_c.pcwrite = 1'b1;
                o_ctrl_c.irwrite = 1'b1;
                o_ctrl_c.alusrcb = SRCB_FOUR;
            end
            STATE_W'(S_DECODE): o_ctrl_c.alusrcb = SRCB_IMMSH;
            STATE_W'(S_MEMADR): begin
                o_ctrl_c.alusrca = 1'b1;
                o_ctrl_c.alusrcb = SRCB_IMM;
            end
            STATE_W'(S_MEMRD): o_ctrl_c.iord = 1'b1;
            STATE_W'(S_MEMWB): begin
                o_ctrl_c.memtoreg = 1'b1;
                o_ctrl_c.regwrite = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                o_ctrl_c.iord     = 1'b1;
                o_ctrl_c.memwrite = 1'b1;
            end
            STATE_W'(S_EXECUTE): begin
                o_ctrl_c.alusrca = 1'b1;
                o_ctrl_c.alusrcb = SRCB_B;
                o_ctrl_c.aluop   = ALUOP_FUNCT;
            end
            STATE_W'(S_ALUWB): begin
                o_ctrl_c.regdst   = 1'b1;
                o_ctrl_c.regwrite = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                o_ctrl_c.alusrca = 1'b1;
                o_ctrl_c.alusrcb = SRCB_B;
                o_ctrl_c.aluop   = ALUOP_SUB;
                o_ctrl_c.pcsrc   = PCSRC_ALUOUT;
                o_ctrl_c.branch  = 1'b1;
            end
            STATE_W'(S_ADDIEX): begin
                o_ctrl_c.alusrca = 1'b1;
                o_ctrl_c.alusrcb = SRCB_IMM;
            end
            STATE_W'(S_ADDIWB): o_ctrl_c.regwrite = 1'b1;
            STATE_W'(S_JUMP): begin
                o_ctrl_c.pcsrc   = PCSRC_JUMP;
                o_ctrl_c.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait handshake.
// Define MULTICYCLE_TRAP_EN to trap unknown opcodes in TRAP (illegal_op port) until reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic [STATE_W-1:0] state_o
`ifdef MULTICYCLE_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    ctrl_t              w_ctrl;
    logic               w_in_fetch;
    logic               w_pcwrite;
    logic               w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= STATE_W'(S_FETCH);
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = STATE_W'(S_FETCH);
        case (r_state)
            STATE_W'(S_FETCH):   w_next = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (op)
                    OP_LW, OP_SW: w_next = STATE_W'(S_MEMADR);
                    OP_RTYPE:     w_next = STATE_W'(S_EXECUTE);
                    OP_BEQ:       w_next = STATE_W'(S_BRANCH);
                    OP_ADDI:      w_next = STATE_W'(S_ADDIEX);
                    OP_J:         w_next = STATE_W'(S_JUMP);
`ifdef MULTICYCLE_TRAP_EN
                    default:      w_next = STATE_W'(S_TRAP);
`else
                    default:      w_next = STATE_W'(S_FETCH);
`endif
                endcase
            end
            STATE_W'(S_MEMADR): begin
                if (op == OP_LW)      w_next = STATE_W'(S_MEMRD);
                else if (op == OP_SW) w_next = STATE_W'(S_MEMWR);
            end
            STATE_W'(S_MEMRD):   w_next = mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
            STATE_W'(S_MEMWR):   w_next = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
            STATE_W'(S_EXECUTE): w_next = STATE_W'(S_ALUWB);
            STATE_W'(S_ADDIEX):  w_next = STATE_W'(S_ADDIWB);
`ifdef MULTICYCLE_TRAP_EN
            STATE_W'(S_TRAP):    w_next = STATE_W'(S_TRAP);
`endif
            default:             w_next = STATE_W'(S_FETCH);
        endcase
    end

    multicycle_outdec #(.STATE_W(STATE_W)) u_outdec (
        .i_state  (r_state),
        .o_ctrl_c (w_ctrl)
    );

    // Fetch's PC/IR updates wait for the instruction word; reset blocks every enable
    assign w_in_fetch = (r_state == STATE_W'(S_FETCH));
    assign w_run      = ~rst;
    assign w_pcwrite  = w_ctrl.pcwrite & (mem_ready | ~w_in_fetch);

    assign pcen     = w_run & (w_pcwrite | (w_ctrl.branch & zero));
    assign irwrite  = w_run & w_ctrl.irwrite & mem_ready;
    assign memwrite = w_run & w_ctrl.memwrite;
    assign regwrite = w_run & w_ctrl.regwrite;
    assign iord     = w_ctrl.iord;
    assign regdst   = w_ctrl.regdst;
    assign memtoreg = w_ctrl.memtoreg;
    assign alusrca  = w_ctrl.alusrca;
    assign alusrcb  = w_ctrl.alusrcb;
    assign pcsrc    = w_ctrl.pcsrc;
    assign aluop    = w_ctrl.aluop;
    assign state_o  = r_state;

`ifdef MULTICYCLE_TRAP_EN
    assign illegal_op = (r_state == STATE_W'(S_TRAP));
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, illegal-op sequence, random run vs. instruction-phase model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;
`ifdef MULTICYCLE_TRAP_EN
    logic       illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .iord      (iord),
        .irwrite   (irwrite),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .state_o   (state_o)
`ifdef MULTICYCLE_TRAP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    logic [17:0] got_all;
    logic [7:0]  got_en;
    assign got_all = {state_o, pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, aluop};
    assign got_en  = {state_o, pcen, irwrite, memwrite, regwrite};

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        logic [3:0] en;
        logic       iord, rd, mt, asa;
        logic [1:0] asb, pcs, aop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [3:0] en,
                       input logic io, input logic rd_, input logic mt_, input logic a_,
                       input logic [1:0] b_, input logic [1:0] p_, input logic [1:0] ao_);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.st = s; v.en = en;
        v.iord = io; v.rd = rd_; v.mt = mt_; v.asa = a_; v.asb = b_; v.pcs = p_; v.aop = ao_;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each instruction is FETCH followed by a fixed list of phases
    int          cur;
    int          q[$];
    logic [5:0]  legal_ops[6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    logic [7:0]  exp_en;

    initial begin
        rst = 1'b1; op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_state", 32'(got_all), 32'({4'd0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00}));
        tick(); tick();
        rst = 1'b0;

        // rst op z mr | st en iord rd mt asa asb pcs aop
        add(0, 6'h00, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h00, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h00, 0, 1,  6, 4'b0000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10);
        add(0, 6'h00, 0, 1,  7, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1,  2, 4'b0000, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        add(0, 6'h23, 0, 0,  3, 4'b0000, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h23, 0, 0,  3, 4'b0000, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1,  3, 4'b0000, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1,  4, 4'b0001, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h04, 1, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h04, 1, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h04, 1, 1,  8, 4'b1000, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
        add(0, 6'h04, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h04, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h04, 0, 1,  8, 4'b0000, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
        add(0, 6'h02, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h02, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h02, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h02, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h02, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h02, 0, 1, 11, 4'b1000, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00);
        add(0, 6'h08, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h08, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h08, 0, 1,  9, 4'b0000, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        add(0, 6'h08, 0, 1, 10, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 1,  2, 4'b0000, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 0,  5, 4'b0010, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(1, 6'h2b, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 1,  0, 4'b1100, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(0, 6'h2b, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(got_all),
                32'({tbl[i].st, tbl[i].en, tbl[i].iord, tbl[i].rd, tbl[i].mt, tbl[i].asa,
                     tbl[i].asb, tbl[i].pcs, tbl[i].aop}));
            tick();
        end

        // Illegal opcode
        rst = 1'b1; op = 6'h3f; mem_ready = 1'b1; zero = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("illegal_fetch", 32'(got_en), 32'({4'd0, 4'b1100}));
        tick();
        @(negedge clk);
        chk("illegal_decode", 32'(got_en), 32'({4'd1, 4'b0000}));
        tick();
`ifdef MULTICYCLE_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            mem_ready = k[0]; zero = 1'b1;
            @(negedge clk);
            chk("trap_hold", 32'({got_en, illegal_op}), 32'({4'd12, 4'b0000, 1'b1}));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("trap_reset", 32'({got_en, illegal_op}), 32'({4'd0, 4'b0000, 1'b0}));
        tick();
        rst = 1'b0;
`else
        mem_ready = 1'b0;
        @(negedge clk);
        chk("illegal_nop", 32'(got_en), 32'({4'd0, 4'b0000}));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        // Random run against the phase-list model
        cur = 0;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            if (cur == 0) begin
`ifdef MULTICYCLE_TRAP_EN
                op = legal_ops[$urandom_range(0, 5)];
`else
                if ($urandom_range(0, 7) == 0) op = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'h01;
                else                           op = legal_ops[$urandom_range(0, 5)];
`endif
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_en = {4'(cur),
                      ((cur == 0) && mem_ready) || (cur == 11) || ((cur == 8) && zero),
                      (cur == 0) && mem_ready,
                      (cur == 5),
                      (cur == 4) || (cur == 7) || (cur == 10)};
            chk("rand", 32'(got_en), 32'(exp_en));
            if (((cur == 0) || (cur == 3) || (cur == 5)) && !mem_ready) begin
                cur = cur;
            end else if (cur == 0) begin
                q.delete();
                case (op)
                    6'h00:   q = '{1, 6, 7};
                    6'h23:   q = '{1, 2, 3, 4};
                    6'h2b:   q = '{1, 2, 5};
                    6'h04:   q = '{1, 8};
                    6'h08:   q = '{1, 9, 10};
                    6'h02:   q = '{1, 11};
                    default: q = '{1};
                endcase
                cur = q.pop_front();
            end else if (q.size() == 0) begin
                cur = 0;
            end else begin
                cur = q.pop_front();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit: a Moore-style FSM that sequences the shared datapath (one memory, one ALU, IR, A/B/ALUOut/MDR registers) over 3-5 cycles per instruction.
- Supports R-type, lw, sw, beq, addi and j.
- Adds a memory wait handshake (mem_ready) so slow instruction and data memories stall the sequence.
- Its aluop output feeds the existing ALU decoder unchanged.

Parameters:
- STATE_W, 4, width of the state register and the state_o debug port (must be at least 4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  opcode from the instruction register (stable after FETCH)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = MDR
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
- state_o  out  STATE_W  current state (debug)

Behaviour:
- Reset: rst high asynchronously forces state to FETCH.
  - While rst is high, pcen, irwrite, memwrite and regwrite are 0.
  - Mux selects take the FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, aluop=00.
  - Reset mid-instruction abandons the instruction; no partial write completes after rst rises.
- Outputs are decoded from state. The only Mealy terms are the mem_ready gating noted below and pcen's dependence on zero.
- Any control signal not listed for a state is 0 in that state.
- States, asserted outputs, and transitions:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
    - irwrite and pcwrite = mem_ready.
    - Stay while mem_ready=0; go to DECODE when it is 1.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00.
    - lw/sw -> MEMADR, R-type(000000) -> EXECUTE, beq(000100) -> BRANCH, addi(001000) -> ADDIEX, j(000010) -> JUMP.
    - Any other opcode -> FETCH, or TRAP when the optional feature is enabled.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00.
    - lw(100011) -> MEMRD; sw(101011) -> MEMWR.
  - MEMRD(3): iord=1.
    - Stay until mem_ready=1, then go to MEMWB.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR(5): iord=1, memwrite=1. memwrite is held for the whole wait.
    - Leave to FETCH in the cycle mem_ready=1.
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB(7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1 -> FETCH.
- Unused state encodings: all enables 0; next state FETCH.
- Latency, counted in cycles with mem_ready tied high:
  - lw 5; R-type and addi 4; sw 4; beq and j 3.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- Write enables (regwrite, memwrite, irwrite, pcen) never assert in the same cycle as a state whose table does not list them.

Optional Feature:
- Macro: MULTICYCLE_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE enters TRAP(12).
  - In TRAP all enables are 0, and an extra output port illegal_op (1 bit) is 1.
  - TRAP is exited only by rst.
- Undefined:
  - An unknown opcode returns to FETCH; the instruction executes as a NOP.
  - The illegal_op port is absent.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings (FETCH..TRAP);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - aluop codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alusrcb and pcsrc select codes.
- One natural sub-module, multicycle_outdec: combinational state -> control word. The top keeps the state register, next-state logic, mem_ready gating and pcen.

Test Plan:
- Reset: assert rst mid-MEMWR (op=101011) -> state_o=0 immediately, memwrite=0, pcen=0; after release with mem_ready=1, irwrite=1 in the first cycle.
- R-type: op=000000, mem_ready=1 -> states 0,1,6,7,0; aluop=10 in EXECUTE; regwrite=1 and regdst=1 only in ALUWB.
- lw with wait: op=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 in all three MEMRD cycles; memtoreg=1 and regwrite=1 in MEMWB.
- beq: op=000100 with zero=1 -> pcen=1, pcsrc=01 in BRANCH; with zero=0 -> pcen=0; both runs return to FETCH after 3 cycles.
- Fetch stall and jump: mem_ready=0 for 3 cycles in FETCH -> irwrite=0 and pcen=0 throughout; then j (op=000010) -> JUMP with pcsrc=10, pcen=1.
- Illegal op 111111: without MULTICYCLE_TRAP_EN -> returns to FETCH, no write enables asserted; with it -> state_o=12 and illegal_op=1, held until rst.
